// File: rtl/svc_rv_mc_seq.sv
// Multi-cycle DIV/REM sequencer for the RISC-V EX stage: captures operands, stalls the pipe, starts the divider.
// Optional early-out for divide-by-zero and signed overflow is enabled by defining SVC_RV_MC_EARLY_OUT_EN.
module svc_rv_mc_seq #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid_ex,
  input  logic            is_div_ex,
  input  logic            is_signed_ex,
  input  logic            flush_ex,
  input  logic [XLEN-1:0] fwd_rs1_ex,
  input  logic [XLEN-1:0] fwd_rs2_ex,
  output logic            is_mc,
  output logic [XLEN-1:0] mc_rs1,
  output logic [XLEN-1:0] mc_rs2,
  output logic            div_start,
  output logic            stall_mc,
  output logic            mc_done,
  output logic            mc_dz,
  output logic            mc_ovf
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dz_q;
  logic             ovf_q;
  logic             dz_c;
  logic             ovf_c;
  logic             early;
  logic             start;

`ifdef SVC_RV_MC_EARLY_OUT_EN
  assign dz_c  = (fwd_rs2_ex == '0);
  assign ovf_c = is_signed_ex & (fwd_rs1_ex == {1'b1, {(XLEN-1){1'b0}}}) & (fwd_rs2_ex == '1);
`else
  logic unused_signed;
  assign unused_signed = is_signed_ex;
  assign dz_c          = 1'b0;
  assign ovf_c         = 1'b0;
`endif

  assign early = dz_c | ovf_c;
  // Gated by rst_n so a div sitting in EX during reset cannot pulse div_start.
  assign start = rst_n & (state == IDLE) & op_valid_ex & is_div_ex & ~flush_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      mc_rs1 <= '0;
      mc_rs2 <= '0;
      dz_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      cnt    <= CNT_W'(DIV_CYCLES - 1);
      mc_rs1 <= fwd_rs1_ex;
      mc_rs2 <= fwd_rs2_ex;
      dz_q   <= dz_c;
      ovf_q  <= ovf_c;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    is_mc     = 1'b0;
    div_start = 1'b0;
    stall_mc  = 1'b0;
    mc_done   = 1'b0;
    mc_dz     = 1'b0;
    mc_ovf    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall_mc = 1'b1;
          if (early) begin
            state_nxt = DONE;
          end else begin
            div_start = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        is_mc    = 1'b1;
        stall_mc = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        is_mc     = 1'b1;
        mc_done   = 1'b1;
        mc_dz     = dz_q;
        mc_ovf    = ovf_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A killed instruction must never retire, whatever state it was in.
    if (flush_ex) begin
      state_nxt = IDLE;
      mc_done   = 1'b0;
      mc_dz     = 1'b0;
      mc_ovf    = 1'b0;
    end
    if (!rst_n) begin
      state_nxt = IDLE;
      is_mc     = 1'b0;
      div_start = 1'b0;
      stall_mc  = 1'b0;
      mc_done   = 1'b0;
      mc_dz     = 1'b0;
      mc_ovf    = 1'b0;
    end
  end

endmodule

// File: tb/tb_svc_rv_mc_seq.sv
// Bench for svc_rv_mc_seq: three latencies (32, 4, 1) share one stimulus stream, checked against a
// cycle-indexed reference model; early-out expectations follow SVC_RV_MC_EARLY_OUT_EN.
module tb_svc_rv_mc_seq;

`ifdef SVC_RV_MC_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        op_valid_ex  = 1'b0;
  logic        is_div_ex    = 1'b0;
  logic        is_signed_ex = 1'b0;
  logic        flush_ex     = 1'b0;
  logic [31:0] fwd_rs1_ex   = '0;
  logic [31:0] fwd_rs2_ex   = '0;

  logic        is_mc_o     [3];
  logic        div_start_o [3];
  logic        stall_o     [3];
  logic        done_o      [3];
  logic        dz_o        [3];
  logic        ovf_o       [3];
  logic [31:0] rs1_o       [3];
  logic [31:0] rs2_o       [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  svc_rv_mc_seq #(.XLEN(32), .DIV_CYCLES(32)) d32 (
    .clk(clk), .rst_n(rst_n), .op_valid_ex(op_valid_ex), .is_div_ex(is_div_ex),
    .is_signed_ex(is_signed_ex), .flush_ex(flush_ex), .fwd_rs1_ex(fwd_rs1_ex), .fwd_rs2_ex(fwd_rs2_ex),
    .is_mc(is_mc_o[0]), .mc_rs1(rs1_o[0]), .mc_rs2(rs2_o[0]), .div_start(div_start_o[0]),
    .stall_mc(stall_o[0]), .mc_done(done_o[0]), .mc_dz(dz_o[0]), .mc_ovf(ovf_o[0]));

  svc_rv_mc_seq #(.XLEN(32), .DIV_CYCLES(4)) d4 (
    .clk(clk), .rst_n(rst_n), .op_valid_ex(op_valid_ex), .is_div_ex(is_div_ex),
    .is_signed_ex(is_signed_ex), .flush_ex(flush_ex), .fwd_rs1_ex(fwd_rs1_ex), .fwd_rs2_ex(fwd_rs2_ex),
    .is_mc(is_mc_o[1]), .mc_rs1(rs1_o[1]), .mc_rs2(rs2_o[1]), .div_start(div_start_o[1]),
    .stall_mc(stall_o[1]), .mc_done(done_o[1]), .mc_dz(dz_o[1]), .mc_ovf(ovf_o[1]));

  svc_rv_mc_seq #(.XLEN(32), .DIV_CYCLES(1)) d1 (
    .clk(clk), .rst_n(rst_n), .op_valid_ex(op_valid_ex), .is_div_ex(is_div_ex),
    .is_signed_ex(is_signed_ex), .flush_ex(flush_ex), .fwd_rs1_ex(fwd_rs1_ex), .fwd_rs2_ex(fwd_rs2_ex),
    .is_mc(is_mc_o[2]), .mc_rs1(rs1_o[2]), .mc_rs2(rs2_o[2]), .div_start(div_start_o[2]),
    .stall_mc(stall_o[2]), .mc_done(done_o[2]), .mc_dz(dz_o[2]), .mc_ovf(ovf_o[2]));

  // Reference model: an op accepted in cycle s retires in cycle s+lat+1 (s+1 on early-out).
  typedef struct {
    bit          active;
    int          done_at;
    logic [31:0] c1;
    logic [31:0] c2;
    bit          dz;
    bit          ovf;
  } mdl_t;

  typedef struct {
    bit          is_mc;
    bit          div_start;
    bit          stall;
    bit          done;
    bit          dz;
    bit          ovf;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

  mdl_t m [3];

  function automatic int lat_of(int k);
    case (k)
      0:       return 32;
      1:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit is_dz_now();
    return EO && (fwd_rs2_ex == 32'h0);
  endfunction

  function automatic bit is_ovf_now();
    return EO && is_signed_ex && (fwd_rs1_ex == 32'h8000_0000) && (fwd_rs2_ex == 32'hFFFF_FFFF);
  endfunction

  function automatic mdl_t model_next(mdl_t mm, int now, int lat);
    mdl_t n;
    n = mm;
    if (!rst_n) begin
      n.active = 1'b0;
      n.c1     = '0;
      n.c2     = '0;
      n.dz     = 1'b0;
      n.ovf    = 1'b0;
    end else if (!mm.active) begin
      if (op_valid_ex && is_div_ex && !flush_ex) begin
        n.active  = 1'b1;
        n.c1      = fwd_rs1_ex;
        n.c2      = fwd_rs2_ex;
        n.dz      = is_dz_now();
        n.ovf     = is_ovf_now();
        n.done_at = (n.dz || n.ovf) ? now + 1 : now + lat + 1;
      end
    end else if (flush_ex || now >= mm.done_at) begin
      n.active = 1'b0;
    end
    return n;
  endfunction

  function automatic exp_t model_out(mdl_t mm);
    exp_t e;
    e.is_mc     = 1'b0;
    e.div_start = 1'b0;
    e.stall     = 1'b0;
    e.done      = 1'b0;
    e.dz        = 1'b0;
    e.ovf       = 1'b0;
    e.rs1       = mm.c1;
    e.rs2       = mm.c2;
    if (rst_n) begin
      if (!mm.active) begin
        e.stall     = op_valid_ex && is_div_ex && !flush_ex;
        e.div_start = e.stall && !(is_dz_now() || is_ovf_now());
      end else if (cyc < mm.done_at) begin
        e.is_mc = 1'b1;
        e.stall = 1'b1;
      end else begin
        e.is_mc = 1'b1;
        e.done  = !flush_ex;
        e.dz    = e.done && mm.dz;
        e.ovf   = e.done && mm.ovf;
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin
    m[0] <= model_next(m[0], cyc, lat_of(0));
    m[1] <= model_next(m[1], cyc, lat_of(1));
    m[2] <= model_next(m[2], cyc, lat_of(2));
    cyc  <= cyc + 1;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit d, input bit s, input bit f,
                       input logic [31:0] a, input logic [31:0] b);
    op_valid_ex  = v;
    is_div_ex    = d;
    is_signed_ex = s;
    flush_ex     = f;
    fwd_rs1_ex   = a;
    fwd_rs2_ex   = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 1, 1, 0, 32'h1234_5678, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({is_mc_o[k], div_start_o[k], stall_o[k], done_o[k], dz_o[k], ovf_o[k]} !== 6'b0) begin
          errors++;
          $display("FAIL reset_ctl[%0d] cycle %0d got=%b want=000000", k, i,
                   {is_mc_o[k], div_start_o[k], stall_o[k], done_o[k], dz_o[k], ovf_o[k]});
        end
        checks++;
        if ({rs1_o[k], rs2_o[k]} !== 64'h0) begin
          errors++;
          $display("FAIL reset_rs[%0d] cycle %0d got=%h_%h want=0", k, i, rs1_o[k], rs2_o[k]);
        end
      end
    end
  endtask

  task automatic test_divu();
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      if (c == 0) drive(1, 1, 0, 0, 32'd100, 32'd7);
      else        drive(c <= 33, c <= 33, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (div_start_o[0] !== (c == 0)) begin
        errors++; $display("FAIL divu_start c=%0d got=%b want=%b", c, div_start_o[0], c == 0);
      end
      checks++;
      if (stall_o[0] !== (c <= 32)) begin
        errors++; $display("FAIL divu_stall c=%0d got=%b want=%b", c, stall_o[0], c <= 32);
      end
      checks++;
      if (done_o[0] !== (c == 33)) begin
        errors++; $display("FAIL divu_done c=%0d got=%b want=%b", c, done_o[0], c == 33);
      end
      checks++;
      if (is_mc_o[0] !== (c >= 1 && c <= 33)) begin
        errors++; $display("FAIL divu_is_mc c=%0d got=%b want=%b", c, is_mc_o[0], c >= 1 && c <= 33);
      end
      if (c >= 1) begin
        checks++;
        if (rs1_o[0] !== 32'd100 || rs2_o[0] !== 32'd7) begin
          errors++; $display("FAIL divu_operands c=%0d got=%0d/%0d want=100/7", c, rs1_o[0], rs2_o[0]);
        end
      end
      if (c == 33) begin
        checks++;
        if ({dz_o[0], ovf_o[0]} !== 2'b00) begin
          errors++; $display("FAIL divu_flags got=%b want=00", {dz_o[0], ovf_o[0]});
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int c = 0; c <= 46; c++) begin
      if (c == 0)       drive(1, 1, 1, 0, 32'd123, 32'd45);
      else if (c < 10)  drive(1, 1, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      else if (c == 10) drive(1, 1, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      else if (c == 11) drive(0, 0, 0, 0, 32'h0, 32'h0);
      else if (c == 12) drive(1, 1, 0, 0, 32'd77, 32'd3);
      else              drive(c <= 45, c <= 45, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      @(negedge clk);
      checks++;
      if (done_o[0] !== (c == 45)) begin
        errors++; $display("FAIL flush_done c=%0d got=%b want=%b", c, done_o[0], c == 45);
      end
      checks++;
      if (div_start_o[0] !== (c == 0 || c == 12)) begin
        errors++; $display("FAIL flush_start c=%0d got=%b want=%b", c, div_start_o[0], c == 0 || c == 12);
      end
      if (c == 11) begin
        checks++;
        if ({stall_o[0], is_mc_o[0]} !== 2'b00) begin
          errors++; $display("FAIL flush_idle got stall,is_mc=%b want=00", {stall_o[0], is_mc_o[0]});
        end
      end
      if (c == 12) begin
        checks++;
        if ({stall_o[0], is_mc_o[0]} !== 2'b10) begin
          errors++; $display("FAIL flush_restart got stall,is_mc=%b want=10", {stall_o[0], is_mc_o[0]});
        end
      end
      if (c == 13) begin
        checks++;
        if (rs1_o[0] !== 32'd77 || rs2_o[0] !== 32'd3 || is_mc_o[0] !== 1'b1) begin
          errors++; $display("FAIL flush_newop got=%0d/%0d is_mc=%b want=77/3 is_mc=1",
                             rs1_o[0], rs2_o[0], is_mc_o[0]);
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c <= 5)       drive(1, 1, 0, 0, 32'd1000, 32'd10);
      else if (c <= 11) drive(1, 1, 0, 0, 32'd2000, 32'd20);
      else              drive(0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if (div_start_o[1] !== (c == 0 || c == 6)) begin
        errors++; $display("FAIL b2b_start c=%0d got=%b want=%b", c, div_start_o[1], c == 0 || c == 6);
      end
      checks++;
      if (done_o[1] !== (c == 5 || c == 11)) begin
        errors++; $display("FAIL b2b_done c=%0d got=%b want=%b", c, done_o[1], c == 5 || c == 11);
      end
      checks++;
      if (stall_o[1] !== (c <= 4 || (c >= 6 && c <= 10))) begin
        errors++; $display("FAIL b2b_stall c=%0d got=%b want=%b", c, stall_o[1], c <= 4 || (c >= 6 && c <= 10));
      end
      if (c == 7) begin
        checks++;
        if (rs1_o[1] !== 32'd2000 || rs2_o[1] !== 32'd20) begin
          errors++; $display("FAIL b2b_operands got=%0d/%0d want=2000/20", rs1_o[1], rs2_o[1]);
        end
      end
      next_cyc();
    end
  endtask

  task automatic test_div1();
    do_reset();
    for (int c = 0; c <= 3; c++) begin
      if (c <= 2) drive(1, 1, 0, 0, 32'd9, 32'd2);
      else        drive(0, 0, 0, 0, 32'h0, 32'h0);
      @(negedge clk);
      checks++;
      if ({div_start_o[2], stall_o[2], is_mc_o[2], done_o[2]} !==
          {c == 0, c <= 1, c == 1 || c == 2, c == 2}) begin
        errors++; $display("FAIL lat1 c=%0d got start,stall,is_mc,done=%b want=%b", c,
                           {div_start_o[2], stall_o[2], is_mc_o[2], done_o[2]},
                           {c == 0, c <= 1, c == 1 || c == 2, c == 2});
      end
      next_cyc();
    end
  endtask

  task automatic test_early_out();
    logic [31:0] a   [4];
    logic [31:0] b   [4];
    bit          sg  [4];
    bit          dzf [4];
    bit          ovf [4];
    a   = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'd7};
    b   = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    sg  = '{1'b1, 1'b1, 1'b0, 1'b0};
    dzf = '{1'b1, 1'b0, 1'b0, 1'b1};
    ovf = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      bit eo;
      int dc;
      eo = EO && (dzf[t] || ovf[t]);
      dc = eo ? 1 : 33;
      do_reset();
      for (int c = 0; c <= dc + 1; c++) begin
        if (c <= dc) drive(1, 1, sg[t], 0, a[t], b[t]);
        else         drive(0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if ({div_start_o[0], stall_o[0], done_o[0]} !== {c == 0 && !eo, c < dc, c == dc}) begin
          errors++; $display("FAIL early[%0d] c=%0d got start,stall,done=%b want=%b", t, c,
                             {div_start_o[0], stall_o[0], done_o[0]}, {c == 0 && !eo, c < dc, c == dc});
        end
        if (c == dc) begin
          checks++;
          if ({dz_o[0], ovf_o[0]} !== {EO && dzf[t], EO && ovf[t]}) begin
            errors++; $display("FAIL early_flags[%0d] got dz,ovf=%b want=%b", t,
                               {dz_o[0], ovf_o[0]}, {EO && dzf[t], EO && ovf[t]});
          end
        end
        next_cyc();
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            $urandom_range(0, 24) == 0, pick(), pick());
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        exp_t e;
        e = model_out(m[k]);
        checks++;
        if ({is_mc_o[k], div_start_o[k], stall_o[k], done_o[k], dz_o[k], ovf_o[k]} !==
            {e.is_mc, e.div_start, e.stall, e.done, e.dz, e.ovf}) begin
          errors++; $display("FAIL rand_ctl[%0d] n=%0d got=%b want=%b", k, n,
                             {is_mc_o[k], div_start_o[k], stall_o[k], done_o[k], dz_o[k], ovf_o[k]},
                             {e.is_mc, e.div_start, e.stall, e.done, e.dz, e.ovf});
        end
        checks++;
        if (rs1_o[k] !== e.rs1 || rs2_o[k] !== e.rs2) begin
          errors++; $display("FAIL rand_rs[%0d] n=%0d got=%h/%h want=%h/%h", k, n,
                             rs1_o[k], rs2_o[k], e.rs1, e.rs2);
        end
      end
      next_cyc();
    end
  endtask

  initial begin
    next_cyc();
    test_reset();
    test_divu();
    test_flush();
    test_back_to_back();
    test_div1();
    test_early_out();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/svc_rv_mc_seq.md
# svc_rv_mc_seq

Sequencer for multi-cycle divide/remainder operations in the RISC-V EX stage. It detects a div/rem op entering EX and captures its forwarded operands on the first cycle. It then stalls the front of the pipeline for a fixed divider latency and drives the `is_mc`, `mc_rs1` and `mc_rs2` inputs of the EX forwarding unit. It also pulses start to the external iterative divider and signals completion so EX can advance.

## Interface
Parameters:
- `XLEN`, 32, operand width
- `DIV_CYCLES`, 32, fixed divider latency in cycles; legal range 1..255

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `op_valid_ex`  in  1  EX holds a valid instruction
- `is_div_ex`  in  1  EX instruction is DIV/DIVU/REM/REMU
- `is_signed_ex`  in  1  signed variant (DIV/REM)
- `flush_ex`  in  1  kill EX instruction (trap/redirect)
- `fwd_rs1_ex`  in  XLEN  forwarded rs1 from the forwarding unit
- `fwd_rs2_ex`  in  XLEN  forwarded rs2 from the forwarding unit
- `is_mc`  out  1  to forwarding unit: use captured operands
- `mc_rs1`  out  XLEN  captured rs1
- `mc_rs2`  out  XLEN  captured rs2
- `div_start`  out  1  one-cycle start pulse to the divider
- `stall_mc`  out  1  hold IF/ID/EX and bubble MEM
- `mc_done`  out  1  divider result valid; EX advances this cycle
- `mc_dz`  out  1  early-out: divide by zero (valid with `mc_done`)
- `mc_ovf`  out  1  early-out: signed overflow (valid with `mc_done`)

## Operation
- States: IDLE, BUSY, DONE. Counter `cnt` has width `$clog2(DIV_CYCLES+1)`.
- Start condition: `start = (state==IDLE) & op_valid_ex & is_div_ex & !flush_ex`.
- IDLE:
  - `is_mc=0`, so forwarding supplies correct operands.
  - On `start`: register `mc_rs1<=fwd_rs1_ex`, `mc_rs2<=fwd_rs2_ex`, `cnt<=DIV_CYCLES-1`.
  - Combinationally assert `div_start=1` and `stall_mc=1`.
  - Next state is BUSY. With early-out enabled and an early-out condition present, next state is DONE instead and `div_start=0`.
- BUSY:
  - `is_mc=1`, `stall_mc=1`.
  - If `cnt==0`, go to DONE; otherwise decrement `cnt`.
- DONE:
  - `is_mc=1`, `mc_done=1`, `stall_mc=0`. EX retires the op using the captured operands.
  - Unconditional transition to IDLE.
  - A div in EX on the following cycle starts a new sequence from IDLE.
- Flush:
  - `flush_ex` in any state forces IDLE next cycle.
  - No `div_start` is issued in the flush cycle, and `mc_done` is suppressed in that cycle.
- `mc_rs1`/`mc_rs2` load only on `start` and hold otherwise.
- `is_mc` decodes purely from state: it is 1 in BUSY and DONE.

## Timing
- Reset (`rst_n=0` at a clock edge):
  - state IDLE, `cnt=0`, `mc_rs1=0`, `mc_rs2=0`.
  - All control outputs are 0: `is_mc`, `div_start`, `stall_mc`, `mc_done`, `mc_dz`, `mc_ovf`.
  - Reset mid-sequence aborts the sequence with no `mc_done`.
- Normal op, with cycle 0 = op first in EX:
  - `div_start` and `stall_mc` high in cycle 0.
  - BUSY in cycles 1..`DIV_CYCLES`, with `stall_mc` high.
  - DONE in cycle `DIV_CYCLES+1`.
  - Total stall is `DIV_CYCLES+1` cycles. `DIV_CYCLES=1` yields exactly one BUSY cycle.
- Early-out op:
  - `stall_mc` high in cycle 0 only.
  - DONE with `mc_done=1` in cycle 1.
- `mc_dz`/`mc_ovf` are registered on `start` and are meaningful only while `mc_done=1`.
- A new start may not occur in DONE. Back-to-back divs are separated by one IDLE cycle.

## Configuration
- Macro: `SVC_RV_MC_EARLY_OUT_EN`.
- Defined: on `start`, the block checks for two early-out conditions:
  - Divide by zero: `fwd_rs2_ex==0` sets `mc_dz`.
  - Signed overflow: `is_signed_ex & fwd_rs1_ex=={1'b1,{XLEN-1{1'b0}}} & fwd_rs2_ex=='1` sets `mc_ovf`.
  - Either condition skips BUSY, takes the 2-cycle path, and suppresses `div_start`.
  - EX substitutes the spec result: quotient −1 or rs1, remainder rs1 or 0.
- Undefined: `mc_dz` and `mc_ovf` are tied to 0, and every div/rem takes the full `DIV_CYCLES+1` stall.

## Test plan
- Reset hold: 3 cycles of `rst_n=0` with `op_valid_ex=is_div_ex=1` -> all outputs 0, no `div_start`.
- DIVU 100/7 with `DIV_CYCLES=32`:
  - `div_start` only in cycle 0, `stall_mc` high in cycles 0..32, `mc_done` only in cycle 33.
  - `is_mc` high in cycles 1..33.
  - `mc_rs1=100`, `mc_rs2=7` held even when `fwd_rs*_ex` changes to 0xDEADBEEF during BUSY.
- Flush at cycle 10 of BUSY -> IDLE at cycle 11, `stall_mc`/`is_mc` drop, no `mc_done`. A new div at cycle 12 starts cleanly.
- Back-to-back divs with `DIV_CYCLES=4`:
  - First op `mc_done` at cycle 5; second op `div_start` at cycle 6 with its own operands.
- Early-out with the macro defined:
  - DIV 5/0 -> `mc_done` and `mc_dz` at cycle 1, no `div_start`.
  - DIV 0x80000000/0xFFFFFFFF -> `mc_ovf` at cycle 1.
  - DIVU of the same values -> full latency, `mc_ovf=0`.
- Early-out inputs with the macro undefined: DIV 5/0 -> full latency, `mc_dz=0`.
